// File: rtl/load_align.sv
// rtl/load_align.sv - memory-read side load aligner
// Pairs registered load requests with the returned word, extracts bytes and merges split beats.
module load_align #(
  parameter int DATA_W = 32,
  parameter int TGT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_second,
  input  logic [TGT_W-1:0]  req_tgt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic [TGT_W-1:0]  result_tgt,
  output logic              pending,
  output logic              protocol_err
);

  typedef enum logic {S_IDLE, S_WAIT_HI} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_req_valid;
  logic [1:0]          r_off;
  logic [1:0]          r_size;
  logic                r_second;
  logic [TGT_W-1:0]    r_tgt;

  logic [DATA_W-1:0]   r_hold;
  logic [TGT_W-1:0]    r_hold_tgt;
  logic                r_hold_word;
  logic [1:0]          r_hold_off;
  logic                r_err;

  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic [TGT_W-1:0]    r_res_tgt;

  logic [DATA_W-1:0]   w_sh;
  logic [DATA_W-1:0]   w_size_mask;
  logic [DATA_W-1:0]   w_hold_mask;
  logic                w_crossing;
  logic [1:0]          w_neg_off;
  logic [DATA_W-1:0]   w_merge_word;
  logic [DATA_W-1:0]   w_merge_dbl;

  logic                w_res_valid;
  logic [DATA_W-1:0]   w_res_data;
  logic [TGT_W-1:0]    w_res_tgt;
  logic [DATA_W-1:0]   w_hold_nxt;
  logic [TGT_W-1:0]    w_hold_tgt_nxt;
  logic                w_hold_word_nxt;
  logic [1:0]          w_hold_off_nxt;
  logic                w_err_nxt;

  assign w_sh        = mem_rdata >> {r_off, 3'b000};
  assign w_hold_mask = {DATA_W{1'b1}} >> {r_off, 3'b000};
  assign w_crossing  = ((r_size == 2'd0) && (r_off != 2'd0)) ||
                       ((r_size == 2'd1) && (r_off == 2'd3));

  always_comb begin
    w_size_mask = '0;
    case (r_size)
      2'd0:    w_size_mask = {DATA_W{1'b1}};
      2'd1:    w_size_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      default: w_size_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
    endcase
  end

  // 4-off in two bits; held offsets are always 1..3 so the wrap never matters
  assign w_neg_off    = 2'd0 - r_hold_off;
  assign w_merge_word = r_hold | (mem_rdata << {w_neg_off, 3'b000});
  assign w_merge_dbl  = {{(DATA_W-16){1'b0}}, mem_rdata[7:0], r_hold[7:0]};

  always_comb begin
    w_state_nxt     = r_state;
    w_res_valid     = 1'b0;
    w_res_data      = '0;
    w_res_tgt       = '0;
    w_hold_nxt      = r_hold;
    w_hold_tgt_nxt  = r_hold_tgt;
    w_hold_word_nxt = r_hold_word;
    w_hold_off_nxt  = r_hold_off;
    w_err_nxt       = r_err;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = '0;
    end else if (r_req_valid) begin
      if (r_second) begin
        if (r_state == S_WAIT_HI) begin
          w_res_valid = 1'b1;
          w_res_data  = r_hold_word ? w_merge_word : w_merge_dbl;
          w_res_tgt   = r_hold_tgt;
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_err_nxt = 1'b1;
        end
      end else begin
        if (r_state == S_WAIT_HI) begin
          w_err_nxt = 1'b1;
        end
        if (w_crossing) begin
          w_hold_nxt      = w_sh & w_hold_mask;
          w_hold_tgt_nxt  = r_tgt;
          w_hold_word_nxt = (r_size == 2'd0);
          w_hold_off_nxt  = r_off;
          w_state_nxt     = S_WAIT_HI;
        end else begin
          w_res_valid = 1'b1;
          w_res_data  = w_sh & w_size_mask;
          w_res_tgt   = r_tgt;
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_off       <= '0;
      r_size      <= '0;
      r_second    <= 1'b0;
      r_tgt       <= '0;
      r_hold      <= '0;
      r_hold_tgt  <= '0;
      r_hold_word <= 1'b0;
      r_hold_off  <= '0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tgt   <= '0;
    end else if (!halt) begin
      r_req_valid <= req_valid & ~flush;
      r_off       <= req_addr[1:0];
      r_size      <= req_size;
      r_second    <= req_second;
      r_tgt       <= req_tgt;
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_tgt  <= w_hold_tgt_nxt;
      r_hold_word <= w_hold_word_nxt;
      r_hold_off  <= w_hold_off_nxt;
      r_err       <= w_err_nxt;
      r_res_valid <= w_res_valid;
      r_res_data  <= w_res_data;
      r_res_tgt   <= w_res_tgt;
    end
  end

  assign result_valid = r_res_valid;
  assign result_data  = r_res_data;
  assign result_tgt   = r_res_tgt;
  assign pending      = (r_state == S_WAIT_HI);
  assign protocol_err = r_err;

endmodule

// File: tb/tb_load_align.sv
// tb/tb_load_align.sv - scoreboard bench for load_align
// Stimulus pushes expected {tgt,data}; a negedge monitor pops and compares on each result pulse.
module tb_load_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_second = 1'b0;
  logic [4:0]  req_tgt = '0;
  logic [31:0] mem_rdata = '0;
  logic        result_valid;
  logic [31:0] result_data;
  logic [4:0]  result_tgt;
  logic        pending;
  logic        protocol_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] exp_q[$];

  load_align #(.DATA_W(32), .TGT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_second(req_second), .req_tgt(req_tgt), .mem_rdata(mem_rdata),
    .result_valid(result_valid), .result_data(result_data), .result_tgt(result_tgt),
    .pending(pending), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got data 0x%08h tgt %0d expected no result", result_data, result_tgt);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("result_data", result_data, e[31:0]);
        check("result_tgt", {27'b0, result_tgt}, {27'b0, e[36:32]});
      end
    end else if (rst_n) begin
      check("idle_tgt_zero", {27'b0, result_tgt}, 32'd0);
    end
  end

  // One access: request cycle, then data cycle with mem_rdata returned.
  task automatic beat(input logic [31:0] addr, input logic [1:0] size, input logic second,
                      input logic [4:0] tgt, input logic [31:0] rdata);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = size;
    req_second = second;
    req_tgt    = tgt;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_second = 1'b0;
    mem_rdata  = rdata;
    @(posedge clk); #1;
  endtask

  task automatic expect_res(input logic [4:0] tgt, input logic [31:0] data);
    exp_q.push_back({tgt, data});
  endtask

  initial begin
    #2;
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_data", result_data, 32'd0);
    check("rst_tgt", {27'b0, result_tgt}, 32'd0);
    check("rst_pending", {31'b0, pending}, 32'd0);
    check("rst_err", {31'b0, protocol_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_res(5'd3, 32'hAABBCCDD); beat(32'h100, 2'd0, 1'b0, 5'd3, 32'hAABBCCDD);
    check("aligned_latency_valid", {31'b0, result_valid}, 32'd1);
    expect_res(5'd4, 32'h00000022); beat(32'h102, 2'd2, 1'b0, 5'd4, 32'h11223344);
    expect_res(5'd5, 32'h00002233); beat(32'h101, 2'd1, 1'b0, 5'd5, 32'h11223344);
    expect_res(5'd6, 32'h00000011); beat(32'h103, 2'd3, 1'b0, 5'd6, 32'h11223344);
    expect_res(5'd2, 32'h0000CAFE); beat(32'h102, 2'd1, 1'b0, 5'd2, 32'hCAFEBABE);

    beat(32'h201, 2'd0, 1'b0, 5'd7, 32'h44332211);
    check("split_word_pending", {31'b0, pending}, 32'd1);
    expect_res(5'd7, 32'h55443322); beat(32'h205, 2'd0, 1'b1, 5'd7, 32'h88776655);
    check("split_word_done", {31'b0, pending}, 32'd0);

    beat(32'h303, 2'd1, 1'b0, 5'd8, 32'hAB000000);
    expect_res(5'd8, 32'h0000CDAB); beat(32'h307, 2'd1, 1'b1, 5'd8, 32'h000000CD);

    beat(32'h402, 2'd0, 1'b0, 5'd9, 32'h44332211);
    halt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("halt_pending", {31'b0, pending}, 32'd1);
    halt = 1'b0;
    expect_res(5'd9, 32'h66554433); beat(32'h406, 2'd0, 1'b1, 5'd9, 32'h88776655);

    beat(32'h503, 2'd0, 1'b0, 5'd1, 32'h44332211);
    check("flush_pre_pending", {31'b0, pending}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_pending", {31'b0, pending}, 32'd0);
    expect_res(5'd10, 32'h01020304); beat(32'h600, 2'd0, 1'b0, 5'd10, 32'h01020304);

    check("err_before", {31'b0, protocol_err}, 32'd0);
    beat(32'h704, 2'd0, 1'b1, 5'd11, 32'h99999999);
    check("orphan_second_err", {31'b0, protocol_err}, 32'd1);

    beat(32'h801, 2'd0, 1'b0, 5'd13, 32'h77777777);
    expect_res(5'd11, 32'hDEADBEEF); beat(32'h900, 2'd0, 1'b0, 5'd11, 32'hDEADBEEF);
    check("restart_pending", {31'b0, pending}, 32'd0);

    beat(32'hA01, 2'd0, 1'b0, 5'd14, 32'h44332211);
    check("rst_mid_pending", {31'b0, pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, result_valid}, 32'd0);
    check("rst_mid_data", result_data, 32'd0);
    check("rst_mid_pend", {31'b0, pending}, 32'd0);
    check("rst_mid_err", {31'b0, protocol_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_res(5'd12, 32'h12345678); beat(32'hB00, 2'd0, 1'b0, 5'd12, 32'h12345678);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
